// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-mode encodings
// and the FSM state type.
package dmem_pkg;

  localparam logic [1:0] MODE_WORD   = 2'b00;
  localparam logic [1:0] MODE_HALF_S = 2'b01;
  localparam logic [1:0] MODE_BYTE_S = 2'b10;
  localparam logic [1:0] MODE_BYTE_U = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: extracts and extends load data from a stored
// word, merges sub-word store data into the old word, and flags accesses
// whose address is not aligned to the access size.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mode,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        misaligned
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_shift = {addr_lo, 3'b000};
  assign half_shift = {addr_lo[1], 4'b0000};
  assign sel_byte   = 8'(old_word >> byte_shift);
  assign sel_half   = 16'(old_word >> half_shift);

  // Lane selection, extension and store merge per access mode (little-endian lanes)
  always_comb begin
    load_data  = '0;
    store_word = old_word;
    misaligned = 1'b0;
    case (mode)
      MODE_WORD: begin
        load_data  = old_word;
        store_word = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      MODE_HALF_S: begin
        load_data  = {{16{sel_half[15]}}, sel_half};
        store_word = (old_word & ~(32'h0000_FFFF << half_shift))
                   | (32'(wdata[15:0]) << half_shift);
        misaligned = addr_lo[0];
      end
      MODE_BYTE_S: begin
        load_data  = {{24{sel_byte[7]}}, sel_byte};
        store_word = (old_word & ~(32'h0000_00FF << byte_shift))
                   | (32'(wdata[7:0]) << byte_shift);
      end
      default: begin
        load_data  = {24'h0, sel_byte};
        store_word = (old_word & ~(32'h0000_00FF << byte_shift))
                   | (32'(wdata[7:0]) << byte_shift);
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with a valid/ready request channel and
// a fixed-latency one-cycle response pulse. Sub-word stores are supported
// only when DMEM_BYTE_STORE_EN is defined; otherwise they return an error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_read,
  input  logic [1:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           cap_write, cap_read;
  logic [1:0]     cap_mode;
  logic [AW-1:0]  cap_idx;
  logic [1:0]     cap_lo;
  logic [31:0]    cap_wdata;

  logic           accept;
  logic           enter_resp;
  logic [31:0]    old_word;
  logic [31:0]    load_data;
  logic [31:0]    store_word;
  logic           misaligned;
  logic           mode_err;
  logic           req_err;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_q == BUSY) && (cnt_q == '0);
  assign old_word   = mem[cap_idx];

`ifdef DMEM_BYTE_STORE_EN
  assign mode_err = 1'b0;
`else
  assign mode_err = cap_write && (cap_mode != MODE_WORD);
`endif

  assign req_err = (cap_read && cap_write)
                 || ((cap_read || cap_write) && misaligned)
                 || mode_err;

  dmem_lane_align u_align (
    .addr_lo    (cap_lo),
    .mode       (cap_mode),
    .old_word   (old_word),
    .wdata      (cap_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned)
  );

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: accept into BUSY, count down to zero, then one RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture every request field at the accept edge so inputs may move on
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_read  <= 1'b0;
      cap_mode  <= MODE_WORD;
      cap_idx   <= '0;
      cap_lo    <= 2'b00;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_read  <= req_read;
      cap_mode  <= req_mode;
      cap_idx   <= req_addr[AW+1:2];
      cap_lo    <= req_addr[1:0];
      cap_wdata <= req_wdata;
    end
  end

  // Response outputs are driven only during the single RESP cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (enter_resp) begin
      resp_valid <= 1'b1;
      resp_error <= req_err;
      resp_rdata <= (cap_read && !req_err) ? load_data : 32'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end
  end

  // Array write commits on the RESP-entry edge; reset on that edge drops it
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cap_write && !req_err) begin
      mem[cap_idx] <= store_word;
    end
  end

endmodule
